// File: rtl/xadc_pkg.sv
// rtl/xadc_pkg.sv - shared XADC code constants and averager state type
package xadc_pkg;

  localparam int ADC_BITS    = 12;
  localparam int ADC_LSB_POS = 4;

  localparam logic [ADC_BITS-1:0] CLIP_HI = 12'hFFF;
  localparam logic [ADC_BITS-1:0] CLIP_LO = 12'h000;

  typedef enum logic {
    FILL = 1'b0,
    DUMP = 1'b1
  } avg_state_t;

endpackage

// File: rtl/xadc_sample_averager.sv
// rtl/xadc_sample_averager.sv - windowed mean of 2^AVG_LOG2 XADC codes, held for the UART stage
// Optional macro CLIP_DETECT_EN compiles in per-window clip detection; otherwise clip_flag is 0.
module xadc_sample_averager
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [15:0] avg_out,
  output logic        avg_valid,
  output logic        avg_stb,
  output logic        clip_flag
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int AW     = ADC_BITS + AVG_LOG2;
  localparam int CW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int HALF_I = N >> 1;
  // A one-sample window is always on its last sample.
  localparam avg_state_t RESET_STATE = (N == 1) ? DUMP : FILL;

  logic                s1_valid;
  logic [ADC_BITS-1:0] s1_code;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       cnt;
  avg_state_t          state, state_next;
  logic                acc_en, dump_en;
  logic [AW-1:0]       sum;
  logic [ADC_BITS-1:0] mean;
  logic                unused_low_bits;

  assign unused_low_bits = ^do_in[ADC_LSB_POS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= drdy_in;
      if (drdy_in)
        s1_code <= do_in[ADC_LSB_POS +: ADC_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RESET_STATE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (s1_valid) begin
      if (state == DUMP)
        state_next = (N == 1) ? DUMP : FILL;
      else if (int'(cnt) == N - 2)
        state_next = DUMP;
    end
  end

  always_comb begin
    acc_en  = 1'b0;
    dump_en = 1'b0;
    if (s1_valid) begin
      if (state == DUMP)
        dump_en = 1'b1;
      else
        acc_en = 1'b1;
    end
  end

  // Worst case sum plus half stays below 2^AW, so no carry bit is needed.
  assign sum  = acc + AW'(s1_code) + AW'(HALF_I);
  assign mean = ADC_BITS'(sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (dump_en) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_en) begin
      acc <= acc + AW'(s1_code);
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_out   <= '0;
      avg_valid <= 1'b0;
      avg_stb   <= 1'b0;
    end else begin
      avg_stb <= dump_en;
      if (dump_en) begin
        avg_out   <= {mean, {ADC_LSB_POS{1'b0}}};
        avg_valid <= 1'b1;
      end
    end
  end

`ifdef CLIP_DETECT_EN
  logic code_clip;
  logic clip_acc;

  assign code_clip = (s1_code == CLIP_HI) || (s1_code == CLIP_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_acc  <= 1'b0;
      clip_flag <= 1'b0;
    end else if (dump_en) begin
      clip_acc  <= 1'b0;
      clip_flag <= clip_acc | code_clip;
    end else if (acc_en) begin
      clip_acc <= clip_acc | code_clip;
    end
  end
`else
  assign clip_flag = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_sample_averager.sv
// tb/tb_xadc_sample_averager.sv - checks averagers with windows of 1, 4 and 16 against a window-sum model
module tb_xadc_sample_averager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] avg_o [3];
  logic        av [3];
  logic        st [3];
  logic        cf [3];

  always #5 clk = ~clk;

  xadc_sample_averager #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .drdy_in(drdy), .do_in(din),
    .avg_out(avg_o[0]), .avg_valid(av[0]), .avg_stb(st[0]), .clip_flag(cf[0]));
  xadc_sample_averager #(.AVG_LOG2(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .drdy_in(drdy), .do_in(din),
    .avg_out(avg_o[1]), .avg_valid(av[1]), .avg_stb(st[1]), .clip_flag(cf[1]));
  xadc_sample_averager #(.AVG_LOG2(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .drdy_in(drdy), .do_in(din),
    .avg_out(avg_o[2]), .avg_valid(av[2]), .avg_stb(st[2]), .clip_flag(cf[2]));

`ifdef CLIP_DETECT_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  typedef struct {
    int          due;
    int          d;
    logic [15:0] avg;
    logic        clip;
  } pend_t;

  int          lg [3] = '{0, 2, 4};
  int          m_cnt [3];
  int          m_sum [3];
  bit          m_clip [3];
  logic [15:0] e_avg [3];
  logic        e_valid [3];
  logic        e_stb [3];
  logic        e_clip [3];
  int          stb_cnt [3];
  pend_t       pq [$];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0; m_sum[d] = 0; m_clip[d] = 0;
      e_avg[d] = '0; e_valid[d] = 0; e_stb[d] = 0; e_clip[d] = 0;
      stb_cnt[d] = 0;
    end
  endtask

  // Window rule: mean = (sum + N/2) / N, reported one registered stage after capture.
  task automatic model_sample(input logic [11:0] code);
    pend_t p;
    int    n;
    for (int d = 0; d < 3; d++) begin
      n = 1 << lg[d];
      m_sum[d] += int'(code);
      m_clip[d] |= (code == 12'h000) || (code == 12'hFFF);
      m_cnt[d]++;
      if (m_cnt[d] == n) begin
        p.due  = cyc + 2;
        p.d    = d;
        p.avg  = {12'((m_sum[d] + n / 2) / n), 4'h0};
        p.clip = m_clip[d] & CLIP_ON;
        pq.push_back(p);
        m_cnt[d] = 0; m_sum[d] = 0; m_clip[d] = 0;
      end
    end
  endtask

  task automatic step(input bit dr, input logic [11:0] code);
    pend_t p;
    @(posedge clk);
    cyc++;
    #1;
    drdy = dr;
    din  = {code, 4'($urandom)};
    if (dr) model_sample(code);
    @(negedge clk);
    for (int d = 0; d < 3; d++) e_stb[d] = 0;
    while (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      e_avg[p.d]   = p.avg;
      e_clip[p.d]  = p.clip;
      e_valid[p.d] = 1'b1;
      e_stb[p.d]   = 1'b1;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("avg%0d", d), avg_o[d], e_avg[d]);
      chk($sformatf("valid%0d", d), 16'(av[d]), 16'(e_valid[d]));
      chk($sformatf("stb%0d", d), 16'(st[d]), 16'(e_stb[d]));
      chk($sformatf("clip%0d", d), 16'(cf[d]), 16'(e_clip[d]));
      if (st[d] === 1'b1) stb_cnt[d]++;
    end
  endtask

  // Reset lands mid-cycle, away from any clock edge, so it must act asynchronously.
  task automatic do_reset();
    @(posedge clk);
    cyc++;
    #3;
    rst_n = 1'b0;
    drdy  = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_avg%0d", d), avg_o[d], 16'h0000);
      chk($sformatf("rst_valid%0d", d), 16'(av[d]), 16'h0);
      chk($sformatf("rst_stb%0d", d), 16'(st[d]), 16'h0);
      chk($sformatf("rst_clip%0d", d), 16'(cf[d]), 16'h0);
    end
    model_clear();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000);
  endtask

  initial begin
    logic [11:0] code;
    int          r;
    model_clear();

    do_reset();
    step(1, 12'h100); step(0, 0); step(1, 12'h101); step(1, 12'h102);
    step(0, 0); step(1, 12'h103);
    flush(3);
    chk("t1_avg", avg_o[1], 16'h1020);
    chk("t1_valid", 16'(av[1]), 16'h1);

    do_reset();
    for (int i = 0; i < 32; i++) step(1, 12'hABC);
    flush(3);
    chk("t2_avg", avg_o[2], 16'hABC0);
    chk("t2_pulses16", 16'(stb_cnt[2]), 16'd2);
    chk("t2_pulses4", 16'(stb_cnt[1]), 16'd8);
    chk("t2_pulses1", 16'(stb_cnt[0]), 16'd32);

    do_reset();
    for (int i = 0; i < 16; i++) step(1, 12'hFFF);
    flush(3);
    chk("t3_full", avg_o[2], 16'hFFF0);
    chk("t3_clip", 16'(cf[2]), 16'(CLIP_ON));
    for (int i = 0; i < 16; i++) step(1, 12'h800);
    flush(3);
    chk("t3_mid", avg_o[2], 16'h8000);
    chk("t3_noclip", 16'(cf[2]), 16'h0);

    do_reset();
    step(1, 12'h3FF); step(1, 12'h3FF);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 12'h200);
    flush(3);
    chk("t4_avg", avg_o[1], 16'h2000);

    do_reset();
    step(1, 12'h001); step(0, 0); step(0, 0);
    chk("t5_first", avg_o[0], 16'h0010);
    step(1, 12'h7FF);
    flush(3);
    chk("t5_second", avg_o[0], 16'h7FF0);
    chk("t5_pulses", 16'(stb_cnt[0]), 16'd2);

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 12'h000);
    flush(3);
    chk("t6_zero_avg", avg_o[1], 16'h0000);
    chk("t6_zero_clip", 16'(cf[1]), 16'(CLIP_ON));

    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      code = (r == 0) ? 12'h000 : (r == 1) ? 12'hFFF : 12'($urandom);
      step($urandom_range(0, 2) != 0, code);
    end
    flush(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
